silencer_step: RTL and testbench
================================

// Module: silencer_step
// PURPOSE
//  Per-transducer slew limiter directly downstream of the STM stage: takes its INTENSITY/PHASE/DOUT_VALID
//  stream (DEPTH beats per update, transducer 0..DEPTH-1 in order) and moves each transducer's held
//  value toward its target by at most a programmable step per update. Suppresses audible edges; feeds PWM.
// PARAMETERS
//  DEPTH  249  transducers per frame (beats per burst); must be >= 3
// PORTS
//  CLK             in   1   system clock; single clock domain
//  RESET_N         in   1   asynchronous, active-low reset
//  DIN_VALID       in   1   beat valid from STM stage (contiguous burst of DEPTH beats)
//  INTENSITY_IN    in   8   target intensity for current transducer
//  PHASE_IN        in   8   target phase for current transducer (modulo 256)
//  STEP_INTENSITY  in   16  max intensity change per update, 8.8 fixed point; 0 = bypass
//  STEP_PHASE      in   16  max phase change per update, 8.8 fixed point; 0 = bypass
//  INTENSITY_OUT   out  8   slewed intensity (integer part of held state)
//  PHASE_OUT       out  8   slewed phase (integer part of held state)
//  DOUT_VALID      out  1   output beat valid
//  BUSY            out  1   high while state RAM initialisation runs
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> INIT, beat index 0. Async assert; release is synchronised internally.
//  - FSM INIT: writes 0 to state entries 0..DEPTH-1, one per cycle (DEPTH cycles), BUSY=1;
//    DIN_VALID beats are dropped (no DOUT_VALID). Last write -> RUN, BUSY=0 on next cycle.
//  - FSM RUN: each valid beat reads state[idx], computes, writes back, outputs. Latency: 2 cycles
//    (cycle 1 RAM read, cycle 2 compute+register); DOUT_VALID is DIN_VALID delayed 2 cycles.
//  - Beat index: +1 per valid beat, wraps DEPTH-1 -> 0; forced to 0 on any cycle with DIN_VALID=0.
//    No read/write hazard, since the same entry is not revisited within 3 beats (DEPTH >= 3).
//  - State: 16 bits per channel, 8.8 format; target = {IN, 8'h00}.
//  - Intensity: d = target - cur (signed 17b); |d| <= step -> cur = target; else cur +/- step.
//    Never wraps or overshoots.
//  - Phase: d = (target - cur) mod 2^16 taken as signed 16b (shortest arc); |d| <= step -> cur = target;
//    else cur = (cur +/- step) mod 2^16. d = -32768 (exact half turn) steps positive.
//  - Step 0 on a channel: cur = target immediately (bypass), and the state is still written.
//  - Step changes take effect on the next beat; no frame alignment.
//  - RESET_N low mid-burst: outputs clear at once, in-flight beats are lost, INIT re-runs.
// CONFIGURATION
//  - SILENCER_PHASE_EN defined: phase slewed as above; state RAM holds intensity+phase (32 bits/entry).
//  - Undefined: PHASE_OUT = PHASE_IN delayed 2 cycles; STEP_PHASE ignored; RAM holds intensity only
//    (16 bits/entry). Latency is identical in both builds.
// STRUCTURE
//  - params package: SilencerStateW=16, SilencerFracW=8, silencer FSM enum {INIT, RUN}.
//  - Sub-module silencer_step_unit: one channel of step arithmetic, parameter WRAP (0 = intensity
//    saturating, 1 = phase modular). Instantiated once per channel.
//  - State storage: simple dual-port RAM, DEPTH entries, inferred in the top level.
// TESTING
//  1 Reset release -> BUSY high for exactly 249 cycles; beats during INIT give no DOUT_VALID.
//    First RUN frame: INTENSITY_IN=255, STEP_INTENSITY=0x0100 -> outputs 1,2,3.. over frames,
//    reaching 255 at frame 255 and holding.
//  2 Phase wrap: state 250, PHASE_IN=4, STEP_PHASE=0x0300 -> outputs 253, then 0, 3, 4
//    (shortest path through 0, no overshoot).
//  3 Bypass: STEP_INTENSITY=0, INTENSITY_IN alternating 0/200 per frame -> output follows exactly,
//    2-cycle latency.
//  4 Burst index: gap (DIN_VALID=0) after 100 beats, then new burst -> first beat uses entry 0;
//    entry 100 untouched until reached.
//  5 RESET_N pulsed low mid-burst -> outputs 0 same cycle, INIT re-runs, old state gone
//    (ramp restarts from 0).
//  6 SILENCER_PHASE_EN undefined: PHASE_IN 0 -> 128 step -> PHASE_OUT=128 after 2 cycles;
//    intensity still slewed.

Source files
------------

// File: rtl/silencer_step_pkg.sv
// Shared parameters and types for the silencer_step slew limiter.
// Optional build macro SILENCER_PHASE_EN (see silencer_step.sv).
package silencer_step_pkg;

    // Held state per channel: 8.8 fixed point.
    localparam int SilencerStateW = 16;
    localparam int SilencerFracW  = 8;
    localparam int SilencerIntW   = SilencerStateW - SilencerFracW;

    typedef enum logic {
        SIL_INIT = 1'b0,
        SIL_RUN  = 1'b1
    } silencer_fsm_e;

    // Promote an 8-bit target to the 8.8 state format.
    function automatic logic [SilencerStateW-1:0] to_state(input logic [SilencerIntW-1:0] v);
        return {v, {SilencerFracW{1'b0}}};
    endfunction

endpackage

// File: rtl/silencer_step_if.sv
// Beat stream and step configuration between the STM stage, the silencer and PWM.
interface silencer_step_if;
    import silencer_step_pkg::*;

    logic                      DIN_VALID;
    logic [SilencerIntW-1:0]   INTENSITY_IN;
    logic [SilencerIntW-1:0]   PHASE_IN;
    logic [SilencerStateW-1:0] STEP_INTENSITY;
    logic [SilencerStateW-1:0] STEP_PHASE;
    logic [SilencerIntW-1:0]   INTENSITY_OUT;
    logic [SilencerIntW-1:0]   PHASE_OUT;
    logic                      DOUT_VALID;
    logic                      BUSY;

    // Upstream side: drives beats and steps, observes results.
    modport master (
        output DIN_VALID, INTENSITY_IN, PHASE_IN, STEP_INTENSITY, STEP_PHASE,
        input  INTENSITY_OUT, PHASE_OUT, DOUT_VALID, BUSY
    );

    // Silencer side.
    modport slave (
        input  DIN_VALID, INTENSITY_IN, PHASE_IN, STEP_INTENSITY, STEP_PHASE,
        output INTENSITY_OUT, PHASE_OUT, DOUT_VALID, BUSY
    );

endinterface

// File: rtl/silencer_step_unit.sv
// One channel of step arithmetic: moves i_cur toward i_target by at most i_step.
// WRAP=0: linear, saturating at the target (intensity).
// WRAP=1: modulo 2^16 along the shortest arc; an exact half turn goes positive (phase).
module silencer_step_unit
    import silencer_step_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [SilencerStateW-1:0] i_cur,
    input  logic [SilencerStateW-1:0] i_target,
    input  logic [SilencerStateW-1:0] i_step,
    output logic [SilencerStateW-1:0] o_next
);
    localparam int W = SilencerStateW;

    logic [W-1:0]        w_diff_mod;
    logic signed [W:0]   w_diff_lin;
    logic [W:0]          w_mag;
    logic                w_up;

    assign w_diff_mod = i_target - i_cur;
    assign w_diff_lin = $signed({1'b0, i_target}) - $signed({1'b0, i_cur});

    // Direction and magnitude of the remaining distance, then the clamped move.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_up  = 1'b1;
        w_mag = '0;
        if (WRAP) begin
            w_up  = !w_diff_mod[W-1] || (w_diff_mod == {1'b1, {(W-1){1'b0}}});
            w_mag = w_diff_mod[W-1] ? ({1'b0, ~w_diff_mod} + {{W{1'b0}}, 1'b1})
                                    : {1'b0, w_diff_mod};
        end else begin
            w_up  = !w_diff_lin[W];
            w_mag = w_diff_lin[W] ? $unsigned(-w_diff_lin) : $unsigned(w_diff_lin);
        end

        o_next = i_target;
        if (i_step != '0 && w_mag > {1'b0, i_step}) begin
            o_next = w_up ? (i_cur + i_step) : (i_cur - i_step);
        end
    end

endmodule

// File: rtl/silencer_step.sv
// Per-transducer slew limiter behind the STM stage.
// Each beat reads the transducer's held 8.8 state, steps it toward the new target
// and writes it back; two-cycle latency (RAM read, then compute + register).
// Build macro SILENCER_PHASE_EN: when defined the phase channel is slewed too and the
// state RAM holds intensity+phase; otherwise phase is passed through with equal latency.
module silencer_step
    import silencer_step_pkg::*;
#(
    parameter int DEPTH = 249
) (
    input  logic          CLK,
    input  logic          RESET_N,
    silencer_step_if.slave bus
);
    localparam int IdxW = $clog2(DEPTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
`ifdef SILENCER_PHASE_EN
    localparam int RamW = 2 * SilencerStateW;
`else
    localparam int RamW = SilencerStateW;
`endif

    logic [1:0]                r_rst_sync;
    logic                      w_rst_n;
    silencer_fsm_e             r_state;
    logic                      r_busy;
    logic [IdxW-1:0]           r_init_idx;
    logic [IdxW-1:0]           r_beat_idx;
    logic                      w_accept;

    logic                      r_s1_valid;
    logic [IdxW-1:0]           r_s1_idx;
    logic [SilencerIntW-1:0]   r_s1_int_tgt;
    logic [SilencerIntW-1:0]   r_s1_ph_in;
    logic [SilencerStateW-1:0] r_s1_step_int;

    logic [RamW-1:0]           r_ram [DEPTH];
    logic [RamW-1:0]           r_rd_data;
    logic                      w_init_we;
    logic                      w_we;
    logic [IdxW-1:0]           w_wr_addr;
    logic [RamW-1:0]           w_wr_data;
    logic [RamW-1:0]           w_next_state;

    logic [SilencerStateW-1:0] w_next_int;
    logic                      r_dout_valid;
    logic [SilencerIntW-1:0]   r_int_out;
    logic [SilencerIntW-1:0]   r_ph_out;

    // Reset asserts asynchronously and releases two clocks later, aligned to CLK.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Control FSM: first cycle after reset arms BUSY, then one zero write per cycle, then RUN.
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= SIL_INIT;
            r_busy     <= 1'b0;
            r_init_idx <= '0;
        end else begin
            case (r_state)
                SIL_INIT: begin
                    if (!r_busy) begin
                        r_busy <= 1'b1;
                    end else if (r_init_idx == LastIdx) begin
                        r_state    <= SIL_RUN;
                        r_busy     <= 1'b0;
                        r_init_idx <= '0;
                    end else begin
                        r_init_idx <= r_init_idx + IdxW'(1);
                    end
                end
                SIL_RUN: r_state <= SIL_RUN;
                default: r_state <= SIL_INIT;
            endcase
        end
    end

    // Beats arriving while the RAM is being cleared are dropped.
    assign w_accept = bus.DIN_VALID && (r_state == SIL_RUN);

    // Beat index: advances per accepted beat, wraps at DEPTH, restarts at 0 on any idle cycle.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n)                    r_beat_idx <= '0;
        else if (!w_accept)              r_beat_idx <= '0;
        else if (r_beat_idx == LastIdx)  r_beat_idx <= '0;
        else                             r_beat_idx <= r_beat_idx + IdxW'(1);
    end

    // Stage 1: capture the beat's target and steps alongside the RAM read.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_idx      <= '0;
            r_s1_int_tgt  <= '0;
            r_s1_ph_in    <= '0;
            r_s1_step_int <= '0;
        end else begin
            r_s1_valid    <= w_accept;
            r_s1_idx      <= r_beat_idx;
            r_s1_int_tgt  <= bus.INTENSITY_IN;
            r_s1_ph_in    <= bus.PHASE_IN;
            r_s1_step_int <= bus.STEP_INTENSITY;
        end
    end

    // State RAM read port (registered).
    // NOTE: the state RAM has no reset; INIT clears it by writing, which keeps it a plain block RAM.
    always_ff @(posedge CLK) begin
        r_rd_data <= r_ram[r_beat_idx];
    end

    assign w_init_we = (r_state == SIL_INIT) && r_busy;
    assign w_we      = w_init_we || r_s1_valid;
    assign w_wr_addr = w_init_we ? r_init_idx : r_s1_idx;
    assign w_wr_data = w_init_we ? '0 : w_next_state;

    // State RAM write port: INIT clearing or stage-2 write-back.
    always_ff @(posedge CLK) begin
        if (w_we) r_ram[w_wr_addr] <= w_wr_data;
    end

    silencer_step_unit #(.WRAP(1'b0)) u_int_step (
        .i_cur    (r_rd_data[SilencerStateW-1:0]),
        .i_target (to_state(r_s1_int_tgt)),
        .i_step   (r_s1_step_int),
        .o_next   (w_next_int)
    );

`ifdef SILENCER_PHASE_EN
    logic [SilencerStateW-1:0] r_s1_step_ph;
    logic [SilencerStateW-1:0] w_next_ph;

    // Stage 1 phase step capture (phase build only).
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) r_s1_step_ph <= '0;
        else          r_s1_step_ph <= bus.STEP_PHASE;
    end

    silencer_step_unit #(.WRAP(1'b1)) u_ph_step (
        .i_cur    (r_rd_data[RamW-1:SilencerStateW]),
        .i_target (to_state(r_s1_ph_in)),
        .i_step   (r_s1_step_ph),
        .o_next   (w_next_ph)
    );

    assign w_next_state = {w_next_ph, w_next_int};
`else
    logic w_unused_step_ph;
    assign w_unused_step_ph = ^bus.STEP_PHASE;
    assign w_next_state     = w_next_int;
`endif

    // Stage 2: register results; outputs hold between beats.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dout_valid <= 1'b0;
            r_int_out    <= '0;
            r_ph_out     <= '0;
        end else begin
            r_dout_valid <= r_s1_valid;
            if (r_s1_valid) r_int_out <= w_next_int[SilencerStateW-1:SilencerFracW];
`ifdef SILENCER_PHASE_EN
            if (r_s1_valid) r_ph_out <= w_next_ph[SilencerStateW-1:SilencerFracW];
`else
            r_ph_out <= r_s1_ph_in;
`endif
        end
    end

    assign bus.INTENSITY_OUT = r_int_out;
    assign bus.PHASE_OUT     = r_ph_out;
    assign bus.DOUT_VALID    = r_dout_valid;
    assign bus.BUSY          = r_busy;

endmodule

// File: tb/tb_silencer_step.sv
// Self-checking bench for silencer_step: directed steps, scoreboard of expected
// output beats produced by an independent behavioural model, plus fixed-value spot checks.
module tb_silencer_step;

    localparam int DEPTH = 249;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] p;
    } exp_t;

    logic clk;
    logic rst_n;
    silencer_step_if bus();

    silencer_step #(.DEPTH(DEPTH)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    int          mon_idx = 0;
    int          m_idx   = 0;
    logic [15:0] m_int [DEPTH];
    logic [15:0] m_ph  [DEPTH];
    logic [7:0]  obs_int [DEPTH];
    logic [7:0]  obs_ph  [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: linear slew clamped at the target.
    function automatic logic [15:0] model_int(input logic [15:0] cur, input logic [7:0] tin,
                                              input logic [15:0] step);
        int c = int'(cur);
        int t = int'(tin) * 256;
        int s = int'(step);
        int d = t - c;
        int a = (d < 0) ? -d : d;
        if (s == 0 || a <= s) return 16'(t);
        return 16'(c + ((d > 0) ? s : -s));
    endfunction

    // Reference model: shortest-arc slew modulo 65536, half turn goes positive.
    function automatic logic [15:0] model_ph(input logic [15:0] cur, input logic [7:0] tin,
                                             input logic [15:0] step);
        int c = int'(cur);
        int t = int'(tin) * 256;
        int s = int'(step);
        int d = t - c;
        int a;
        if (d < -32768) d = d + 65536;
        else if (d > 32767) d = d - 65536;
        if (d == -32768) d = 32768;
        a = (d < 0) ? -d : d;
        if (s == 0 || a <= s) return 16'(t);
        return 16'(c + ((d > 0) ? s : -s));
    endfunction

    task automatic model_clear();
        foreach (m_int[k]) begin
            m_int[k] = '0;
            m_ph[k]  = '0;
        end
    endtask

    // Drive one valid beat and queue its expected result.
    task automatic drive_beat(input logic [7:0] iv, input logic [7:0] pv,
                              input logic [15:0] si, input logic [15:0] sp);
        exp_t e;
        bus.DIN_VALID      = 1'b1;
        bus.INTENSITY_IN   = iv;
        bus.PHASE_IN       = pv;
        bus.STEP_INTENSITY = si;
        bus.STEP_PHASE     = sp;
        m_int[m_idx] = model_int(m_int[m_idx], iv, si);
        e.i = m_int[m_idx][15:8];
`ifdef SILENCER_PHASE_EN
        m_ph[m_idx] = model_ph(m_ph[m_idx], pv, sp);
        e.p = m_ph[m_idx][15:8];
`else
        e.p = pv;
`endif
        sb.push_back(e);
        m_idx = (m_idx == DEPTH - 1) ? 0 : m_idx + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.DIN_VALID = 1'b0;
        m_idx = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic burst(input int n, input logic [7:0] iv, input logic [7:0] pv,
                         input logic [15:0] si, input logic [15:0] sp);
        for (int b = 0; b < n; b++) drive_beat(iv, pv, si, sp);
        idle(4);
    endtask

    // Output monitor: pop and compare each output beat, record it by beat position.
    always @(negedge clk) begin
        if (bus.DOUT_VALID) begin
            check("dout_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("int_out", 32'(bus.INTENSITY_OUT), 32'(mon_e.i));
                check("ph_out", 32'(bus.PHASE_OUT), 32'(mon_e.p));
            end
            obs_int[mon_idx] = bus.INTENSITY_OUT;
            obs_ph[mon_idx]  = bus.PHASE_OUT;
            mon_idx = (mon_idx == DEPTH - 1) ? 0 : mon_idx + 1;
        end else begin
            mon_idx = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy_cnt;
        bit          saw_out;
        bit          done;
        bit          seen;
        logic [7:0]  t2_exp [4];
        logic [7:0]  t6_ph  [2];
        logic [15:0] si;

`ifdef SILENCER_PHASE_EN
        t2_exp = '{8'd253, 8'd0, 8'd3, 8'd4};
        t6_ph  = '{8'd3, 8'd4};
`else
        t2_exp = '{8'd4, 8'd4, 8'd4, 8'd4};
        t6_ph  = '{8'd0, 8'd128};
`endif

        rst_n              = 1'b0;
        bus.DIN_VALID      = 1'b0;
        bus.INTENSITY_IN   = '0;
        bus.PHASE_IN       = '0;
        bus.STEP_INTENSITY = '0;
        bus.STEP_PHASE     = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_dout_valid", 32'(bus.DOUT_VALID), 32'd0);
        check("rst_int_out", 32'(bus.INTENSITY_OUT), 32'd0);
        check("rst_ph_out", 32'(bus.PHASE_OUT), 32'd0);

        // INIT: BUSY width, beats offered during INIT are dropped
        rst_n            = 1'b1;
        bus.DIN_VALID    = 1'b1;
        bus.INTENSITY_IN = 8'd99;
        busy_cnt = 0;
        saw_out  = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (bus.DOUT_VALID) saw_out = 1'b1;
            if (bus.BUSY) busy_cnt++;
            else if (busy_cnt > 0) done = 1'b1;
            if (c == 100) bus.DIN_VALID = 1'b0;
        end
        check("init_done", 32'(done), 32'd1);
        check("init_busy_cycles", 32'(busy_cnt), 32'd249);
        check("init_no_dout", 32'(saw_out), 32'd0);
        @(posedge clk);
        #1;

        // Test 1: ramp 0 -> 255 at one LSB per frame, then hold
        for (int f = 1; f <= 258; f++) begin
            burst(3, 8'd255, 8'd7, 16'h0100, 16'h0000);
            if (f <= 3 || f == 254 || f == 255 || f == 258)
                check("t1_ramp", 32'(obs_int[0]), (f > 255) ? 32'd255 : 32'(f));
        end

        // Test 3: bypass follows exactly, with 2-cycle latency
        for (int f = 0; f < 4; f++) begin
            burst(3, (f % 2 == 1) ? 8'd200 : 8'd0, 8'd9, 16'h0000, 16'h0000);
            check("t3_bypass", 32'(obs_int[2]), (f % 2 == 1) ? 32'd200 : 32'd0);
        end
        drive_beat(8'd200, 8'd9, 16'h0000, 16'h0000);
        bus.DIN_VALID = 1'b0;
        m_idx = 0;
        @(negedge clk);
        check("t3_latency_c1", 32'(bus.DOUT_VALID), 32'd0);
        @(negedge clk);
        check("t3_latency_c2", 32'(bus.DOUT_VALID), 32'd1);
        idle(3);

        // Test 2: phase wrap through 0 along the short arc
        burst(3, 8'd200, 8'd250, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            burst(3, 8'd200, 8'd4, 16'h0000, 16'h0300);
            check("t2_phase_wrap", 32'(obs_ph[0]), 32'(t2_exp[k]));
        end

        // Test 6: phase step 0 -> 128 while intensity keeps slewing
        burst(3, 8'd0, 8'd0, 16'h0100, 16'h0100);
        check("t6_int_a", 32'(obs_int[0]), 32'd199);
        check("t6_ph_a", 32'(obs_ph[0]), 32'(t6_ph[0]));
        burst(3, 8'd0, 8'd128, 16'h0100, 16'h0100);
        check("t6_int_b", 32'(obs_int[0]), 32'd198);
        check("t6_ph_b", 32'(obs_ph[0]), 32'(t6_ph[1]));

        // Test 4: gap restarts the index; entry 100 untouched until reached
        burst(100, 8'd50, 8'd0, 16'h0000, 16'h0000);
        burst(101, 8'd60, 8'd0, 16'h0100, 16'h0000);
        check("t4_entry0", 32'(obs_int[0]), 32'd51);
        check("t4_entry99", 32'(obs_int[99]), 32'd51);
        check("t4_entry100", 32'(obs_int[100]), 32'd1);

        // Full frame plus wrap into entries 0 and 1, random targets and per-beat steps
        for (int b = 0; b < DEPTH + 2; b++) begin
            si = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h2000));
            drive_beat(8'($urandom), 8'($urandom), si,
                       ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h9000)));
        end
        idle(4);

        // Test 5: reset mid-burst clears outputs at once and restarts from zero state
        burst(3, 8'd200, 8'd0, 16'h0000, 16'h0000);
        for (int b = 0; b < 5; b++) drive_beat(8'd200, 8'd0, 16'h0000, 16'h0000);
        #2;
        rst_n = 1'b0;
        bus.DIN_VALID = 1'b0;
        #1;
        check("t5_dout_valid", 32'(bus.DOUT_VALID), 32'd0);
        check("t5_int_out", 32'(bus.INTENSITY_OUT), 32'd0);
        check("t5_ph_out", 32'(bus.PHASE_OUT), 32'd0);
        check("t5_busy", 32'(bus.BUSY), 32'd0);
        sb.delete();
        m_idx = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (bus.BUSY) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check("t5_reinit_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        burst(3, 8'd255, 8'd0, 16'h0100, 16'h0000);
        check("t5_ramp_restart", 32'(obs_int[0]), 32'd1);

        idle(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
